sram_arbiter: RTL and testbench

Two-requester access arbiter and sequencer for the team's small asynchronous-write register-file SRAM (DATA_WIDTH × 2**ADDR_WIDTH). It accepts read/write commands from ports A and B and grants at most one per cycle. It registers the granted command to drive the memory's write-enable, address and data pins, and returns read data to the owning requester. It sits between two client blocks, for example a producer and a consumer, and the single memory instance.

---
 rtl/sram_arb_pkg.sv | 29 ++
 rtl/sram_arbiter_rr_arb2.sv | 44 ++++
 rtl/sram_arbiter.sv | 115 +++++++++++
 tb/tb_sram_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and reset values for sram_arbiter
// Purpose: requester owner encoding, granted-command struct and reset constants
//          shared by sram_arbiter and rr_arb2.
// Ports:   none (package).
// Config:  SRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration in rr_arb2.
package sram_arb_pkg;

  // Default geometry of the register-file SRAM; cmd_t is sized from these,
  // so the top-level parameters must match them.
  localparam int CMD_DATA_WIDTH = 8;
  localparam int CMD_ADDR_WIDTH = 2;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  typedef struct packed {
    logic                      wr;
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [CMD_DATA_WIDTH-1:0] data;
  } cmd_t;

  // B counts as the most recent winner out of reset so A takes the first tie.
  localparam owner_t RST_LAST  = OWN_B;
  localparam owner_t RST_OWNER = OWN_A;
  localparam cmd_t   RST_CMD   = '0;

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// rtl/sram_arbiter_rr_arb2.sv - two-input arbiter with optional round-robin pointer
// Purpose: combinational one-hot grant between requesters A and B.
// Ports:   clk, reset  - clock and sync active-high reset (round-robin build only)
//          req_a/req_b - requests (already masked by reset in the top)
//          gnt_a/gnt_b - grants, at most one high, exactly one when any req is high
// Config:  SRAM_ARB_ROUND_ROBIN_EN defined   -> ties go to the port that did not win last
//          SRAM_ARB_ROUND_ROBIN_EN undefined -> fixed priority, A always wins ties
module rr_arb2 (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  import sram_arb_pkg::*;

  owner_t last;

  // Pointer moves only when someone is actually granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= RST_LAST;
    end else if (gnt_a) begin
      last <= OWN_A;
    end else if (gnt_b) begin
      last <= OWN_B;
    end
  end

  always_comb begin
    gnt_a = req_a & (~req_b | (last == OWN_B));
    gnt_b = req_b & ~gnt_a;
  end
`else
  assign gnt_a = req_a;
  assign gnt_b = req_b & ~req_a;
`endif

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port arbiter and sequencer for the register-file SRAM
// Purpose: grants one read/write command per cycle from ports A/B, registers it
//          to drive the SRAM pins (stage 1) and returns read data to its owner
//          (stage 2). Grant at t, memory access at t+1, rvalid at t+2.
// Ports:   clk, reset (sync, active-high)
//          x_req/x_wr/x_addr/x_wdata - requester command (x = a, b), held until x_gnt
//          x_gnt                     - command accepted this cycle (combinational)
//          x_rvalid/x_rdata          - read return pulse and held read data
//          mem_wr_en/mem_w_addr/mem_d - SRAM write pins
//          mem_r_addr/mem_q           - SRAM asynchronous read port
// Config:  SRAM_ARB_ROUND_ROBIN_EN enables round-robin tie breaking (see rr_arb2).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = CMD_DATA_WIDTH,
  parameter int ADDR_WIDTH = CMD_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic [DATA_WIDTH-1:0] mem_d,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  logic   req_a_live;
  logic   req_b_live;
  cmd_t   gnt_cmd;
  logic   s1_valid;
  owner_t s1_owner;
  cmd_t   s1_cmd;
  logic   rd_fire;

  // Masking requests keeps grants low while reset is high and stops the
  // round-robin pointer from moving during reset.
  assign req_a_live = a_req & ~reset;
  assign req_b_live = b_req & ~reset;

  rr_arb2 u_arb (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    .clk   (clk),
    .reset (reset),
`endif
    .req_a (req_a_live),
    .req_b (req_b_live),
    .gnt_a (a_gnt),
    .gnt_b (b_gnt)
  );

  always_comb begin
    gnt_cmd = '{wr: a_wr, addr: a_addr, data: a_wdata};
    if (b_gnt) begin
      gnt_cmd = '{wr: b_wr, addr: b_addr, data: b_wdata};
    end
  end

  // Stage 1: command register driving the SRAM pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_owner <= RST_OWNER;
      s1_cmd   <= RST_CMD;
    end else begin
      s1_valid <= a_gnt | b_gnt;
      if (a_gnt | b_gnt) begin
        s1_owner <= b_gnt ? OWN_B : OWN_A;
        s1_cmd   <= gnt_cmd;
      end
    end
  end

  // The SRAM writes asynchronously, so the enable is also cut while reset is
  // high: a write caught in stage 1 when reset arrives never reaches the array.
  assign mem_wr_en  = s1_valid & s1_cmd.wr & ~reset;
  assign mem_w_addr = s1_cmd.addr;
  assign mem_r_addr = s1_cmd.addr;
  assign mem_d      = s1_cmd.data;

  // Stage 2: capture the asynchronous read data for the owning port.
  assign rd_fire = s1_valid & ~s1_cmd.wr;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= rd_fire && (s1_owner == OWN_A);
      b_rvalid <= rd_fire && (s1_owner == OWN_B);
      if (rd_fire && (s1_owner == OWN_A)) begin
        a_rdata <= mem_q;
      end
      if (rd_fire && (s1_owner == OWN_B)) begin
        b_rdata <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_w_addr, mem_r_addr;
  logic [DW-1:0] mem_d, mem_q;

  logic [DW-1:0] tb_mem [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_w_addr] <= mem_d;
  end
  assign mem_q = tb_mem[mem_r_addr];

  sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wr_en(mem_wr_en), .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  // kind: 0 = memory write, 1 = memory read, 2 = read return to requester
  typedef struct {
    int            due;
    int            kind;
    bit            own_b;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  req_t          qa[$];
  req_t          qb[$];
  ev_t           sched[$];
  bit            a_hold, b_hold;
  logic [DW-1:0] ref_mem [4];
  bit            last_b;
  logic [DW-1:0] exp_rda, exp_rdb;
  int            cyc, n_vec, n_bad, cnt_ga, cnt_gb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.wr   = 1'($urandom_range(1, 0));
    r.addr = AW'($urandom_range(3, 0));
    r.data = DW'($urandom);
    return r;
  endfunction

  task automatic drive();
    a_req = (qa.size() > 0) && !a_hold;
    b_req = (qb.size() > 0) && !b_hold;
    if (qa.size() > 0) begin
      a_wr = qa[0].wr; a_addr = qa[0].addr; a_wdata = qa[0].data;
    end
    if (qb.size() > 0) begin
      b_wr = qb[0].wr; b_addr = qb[0].addr; b_wdata = qb[0].data;
    end
  endtask

  // Reference: grants decided from request levels and the last winner; each
  // grant becomes a memory event one cycle later and, for reads, a return
  // event one cycle after that carrying the reference memory contents.
  task automatic check_cycle();
    bit   exp_ga, exp_gb, exp_wen, exp_rva, exp_rvb;
    ev_t  keep[$];
    ev_t  e;
    exp_ga = 0; exp_gb = 0; exp_wen = 0; exp_rva = 0; exp_rvb = 0;
    if (!reset) begin
      if (a_req && b_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        if (last_b) exp_ga = 1; else exp_gb = 1;
`else
        exp_ga = 1;
`endif
      end else begin
        exp_ga = a_req;
        exp_gb = b_req;
      end
    end
    chk("a_gnt", a_gnt, exp_ga);
    chk("b_gnt", b_gnt, exp_gb);

    foreach (sched[i]) begin
      e = sched[i];
      if (e.due != cyc) begin
        keep.push_back(e);
      end else if (e.kind == 0) begin
        exp_wen = !reset;
        if (!reset) begin
          chk("mem_w_addr", mem_w_addr, e.addr);
          chk("mem_d", mem_d, e.data);
          ref_mem[e.addr] = e.data;
        end
      end else if (e.kind == 1) begin
        chk("mem_r_addr", mem_r_addr, e.addr);
        keep.push_back('{cyc + 1, 2, e.own_b, e.addr, ref_mem[e.addr]});
      end else begin
        if (e.own_b) begin exp_rvb = 1; exp_rdb = e.data; end
        else begin exp_rva = 1; exp_rda = e.data; end
      end
    end
    chk("mem_wr_en", mem_wr_en, exp_wen);
    chk("a_rvalid", a_rvalid, exp_rva);
    chk("b_rvalid", b_rvalid, exp_rvb);
    chk("a_rdata", a_rdata, exp_rda);
    chk("b_rdata", b_rdata, exp_rdb);

    if (exp_ga) begin
      keep.push_back('{cyc + 1, a_wr ? 0 : 1, 1'b0, a_addr, a_wdata});
      last_b = 0;
    end
    if (exp_gb) begin
      keep.push_back('{cyc + 1, b_wr ? 0 : 1, 1'b1, b_addr, b_wdata});
      last_b = 1;
    end
    if (a_req && a_gnt === 1'b1) begin void'(qa.pop_front()); cnt_ga++; end
    if (b_req && b_gnt === 1'b1) begin void'(qb.pop_front()); cnt_gb++; end

    if (reset) begin
      keep.delete();
      exp_rda = '0;
      exp_rdb = '0;
      last_b  = 1;
    end
    sched = keep;
    cyc++;
  endtask

  task automatic cycle();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 300 && (qa.size() > 0 || qb.size() > 0); k++) cycle();
    for (int k = 0; k < 4; k++) cycle();
    chk(tag, qa.size() + qb.size(), 0);
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0; cnt_ga = 0; cnt_gb = 0;
    a_hold = 0; b_hold = 0; last_b = 1;
    exp_rda = '0; exp_rdb = '0;
    ref_mem = '{8'h01, 8'h02, 8'h03, 8'h04};
    a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
    reset = 1;
    cycle(); cycle();
    reset = 0;

    // Idle after reset: every output at its reset value.
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("idle_mem_w_addr", mem_w_addr, 0);
      chk("idle_mem_r_addr", mem_r_addr, 0);
      chk("idle_mem_d", mem_d, 0);
    end

    // A writes 0x5A to addr 1, then reads it back on the next grant.
    qa.push_back('{1'b1, 2'd1, 8'h5A});
    qa.push_back('{1'b0, 2'd1, 8'h00});
    drain("t2_drain");
    chk("t2_rdata", a_rdata, 8'h5A);
    chk("t2_mem", tb_mem[1], 8'h5A);

    // Both ports requesting continuously, starting right after reset.
    reset = 1; cycle(); reset = 0;
    cnt_ga = 0; cnt_gb = 0;
    for (int k = 0; k < 8; k++) begin
      qa.push_back('{1'b0, AW'(k), 8'h00});
      qb.push_back('{1'b0, AW'(k + 1), 8'h00});
    end
    for (int k = 0; k < 8; k++) cycle();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    chk("t3_a_grants", cnt_ga, 4);
    chk("t3_b_grants", cnt_gb, 4);
`else
    chk("t3_a_grants", cnt_ga, 8);
    chk("t3_b_grants", cnt_gb, 0);
`endif
    drain("t3_drain");

    // B writes 0x33 to addr 3, A reads addr 3 on the following cycle.
    qb.push_back('{1'b1, 2'd3, 8'h33});
    cycle();
    qa.push_back('{1'b0, 2'd3, 8'h00});
    drain("t4_drain");
    chk("t4_rdata", a_rdata, 8'h33);

    // Reset lands in the cycle after a write grant: the write is lost.
    qa.push_back('{1'b1, 2'd2, 8'hEE});
    cycle();
    reset = 1; cycle(); reset = 0;
    cycle(); cycle();
    chk("t5_mem_kept", tb_mem[2], 8'h03);

    // Sweep all addresses, then read back from both ports at once.
    for (int k = 0; k < 4; k++) qa.push_back('{1'b1, AW'(k), DW'(8'hA0 + k)});
    drain("t6_wr_drain");
    qa.push_back('{1'b0, 2'd0, 8'h00});
    qa.push_back('{1'b0, 2'd2, 8'h00});
    qb.push_back('{1'b0, 2'd1, 8'h00});
    qb.push_back('{1'b0, 2'd3, 8'h00});
    drain("t6_rd_drain");
    for (int k = 0; k < 4; k++) chk("t6_mem", tb_mem[k], 8'hA0 + k);
    chk("t6_a_rdata", a_rdata, 8'hA2);
    chk("t6_b_rdata", b_rdata, 8'hA3);

    // Randomised traffic with withdrawals and occasional resets.
    for (int k = 0; k < 800; k++) begin
      if (qa.size() == 0 && $urandom_range(1, 0) == 1) qa.push_back(rand_req());
      if (qb.size() == 0 && $urandom_range(1, 0) == 1) qb.push_back(rand_req());
      a_hold = ($urandom_range(7, 0) == 0);
      b_hold = ($urandom_range(7, 0) == 0);
      reset  = ($urandom_range(63, 0) == 0);
      cycle();
    end
    reset = 0; a_hold = 0; b_hold = 0;
    drain("rand_drain");
    for (int k = 0; k < 4; k++) chk("rand_mem", tb_mem[k], ref_mem[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
